regfile_write_ctrl: RTL and testbench
=====================================

Name: regfile_write_ctrl

Overview:
Arbitration and sequencing controller for the 32x32 register file's single write port. Shares the port between three sources:
- pipeline writeback (wb)
- host/debug loader (host, valid/ready)
- an internal clear sequencer that rewrites r1..r31 on request.

Sits between the writeback stage / debug bridge and the register file write inputs. Drives a registered stall back to the pipeline.

Parameters:
ADDR_W, 5, register address width
DATA_W, 32, register data width
MAX_WAIT, 8, consecutive denied host cycles before a forced pipeline stall (>=1)
CLEAR_MODE, 1, clear value: 0 = zero, 1 = register index (matches regfile reset contents)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
wb_valid  in  1  writeback write request (no backpressure)
wb_addr  in  ADDR_W  writeback destination register
wb_data  in  DATA_W  writeback data
host_valid  in  1  host write request, held until accepted
host_addr  in  ADDR_W  host destination register
host_data  in  DATA_W  host data
host_ready  out  1  host accept (combinational)
clear_req  in  1  single-cycle pulse: start clear sequence
clear_busy  out  1  clear sequence in progress (registered)
stall_pipe  out  1  pipeline must hold wb_valid=0 this cycle (registered)
protocol_err  out  1  sticky: wb_valid seen while stall_pipe=1
rf_write_en  out  1  register file write enable (registered)
rf_write_address  out  ADDR_W  register file write address (registered)
rf_data_in  out  DATA_W  register file write data (registered)

Behaviour:
- Reset (async, immediate):
  - Outputs rf_write_en, rf_write_address, rf_data_in, clear_busy, stall_pipe and protocol_err are all 0.
  - FSM goes to IDLE; clear counter and wait_cnt are 0.
- FSM states IDLE, CLEAR:
  - IDLE -> CLEAR on clear_req, with clr_cnt=1.
  - CLEAR issues one write per cycle at clr_cnt, with data 0 or clr_cnt per CLEAR_MODE.
  - clr_cnt == 31 -> IDLE after that write. Total 31 cycles.
  - clear_req during CLEAR is ignored.
- clear_busy and stall_pipe are both 1 exactly during the CLEAR cycles.
- Arbitration in IDLE, fixed priority wb > host:
  - host_ready = (state==IDLE) && !wb_valid.
  - Handshake completes when host_valid && host_ready.
  - host_ready is 0 throughout CLEAR.
- clear_req arriving in IDLE: that cycle's wb/host arbitration proceeds normally; the clear starts the next cycle.
- Latency: an accepted write appears on the rf_* outputs one clock after acceptance.
- rf_write_en is 1 for exactly one cycle per accepted write with addr != 0.
- Writes to address 0 from any source are consumed/acknowledged, but rf_write_en stays 0.
- rf_write_address and rf_data_in hold their last values when rf_write_en = 0.
- Starvation:
  - wait_cnt increments each IDLE cycle with host_valid && !host_ready.
  - wait_cnt clears on host acceptance, on host_valid=0, or on entering CLEAR.
  - On the cycle wait_cnt == MAX_WAIT-1 and the host is still denied: stall_pipe = 1 in the next cycle, for exactly one cycle, and wait_cnt clears.
  - In that cycle wb_valid=0 by contract, so the host is granted.
- Contract violation: wb_valid=1 while stall_pipe=1 (forced stall or CLEAR):
  - The wb write is dropped and protocol_err is set.
  - protocol_err holds until reset.
  - Host arbitration is unaffected: host_ready stays 0.
- Reset mid-CLEAR: the sequence aborts with no further writes and the FSM returns to IDLE. The register file reinitializes from the same reset.

Decomposition:
- Shared package holds:
  - ADDR_W and DATA_W defaults, plus NUM_REGS=32.
  - FSM state encoding (IDLE, CLEAR).
  - Source-select encoding (SRC_NONE, SRC_WB, SRC_HOST, SRC_CLR).
- One sub-module: regfile_clear_seq. It owns clr_cnt, busy, the per-cycle write address/data, and the done pulse.
- Arbitration, starvation counter and output registers stay in the top module.

Test Plan:
1. Writeback only:
   - Stimulus: wb_valid=1, wb_addr=3, wb_data=0xDEADBEEF at cycle N.
   - Response: cycle N+1 shows rf_write_en=1, addr 3, data 0xDEADBEEF; cycle N+2 rf_write_en=0.
2. Contention:
   - Stimulus: wb (addr 4, 0x11) and host (addr 5, 0x22) both valid at N; wb_valid=0 at N+1.
   - Response: host_ready=0 at N, 1 at N+1. Writes land: addr 4 at N+1, addr 5 at N+2.
3. Starvation, MAX_WAIT=8:
   - Stimulus: wb_valid continuous from N; host_valid held (addr 7, 0x77). Bench drops wb_valid while stall_pipe=1.
   - Response: stall_pipe=1 at N+8 only; host accepted at N+8; addr 7 written at N+9; protocol_err=0.
4. Clear, CLEAR_MODE=1:
   - Stimulus: clear_req pulse at N.
   - Response: clear_busy=1 and stall_pipe=1 at N+1..N+31. Writes addr k with data k for k=1..31, at N+2..N+32. host_ready=0 throughout.
5. Address zero:
   - Stimulus: host writes addr 0, data 0xFFFFFFFF.
   - Response: host_ready=1 (accepted); rf_write_en stays 0.
6. Reset and contract violation:
   - Reset mid-CLEAR at clr_cnt=10: outputs 0 immediately; no write to addr 11 after reset release.
   - Separately, wb_valid=1 during CLEAR: wb write dropped; protocol_err=1 until next reset.

Source files
------------

// File: rtl/regfile_write_ctrl_pkg.sv
// regfile_write_ctrl_pkg: shared widths, FSM states and write-source encoding for the regfile write controller
package regfile_write_ctrl_pkg;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;
    localparam int NUM_REGS   = 32;
    typedef enum logic {IDLE, CLEAR} state_e;
    typedef enum logic [1:0] {SRC_NONE, SRC_WB, SRC_HOST, SRC_CLR} src_e;
endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: walks r1..r(NUM_REGS-1) one write per cycle after a start pulse
module regfile_clear_seq import regfile_write_ctrl_pkg::*; #(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int CLEAR_MODE = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
    state_e state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    always_comb begin
        busy    = state_q == CLEAR;
        done    = busy && cnt_q == LAST;
        addr    = cnt_q;
        data    = CLEAR_MODE != 0 ? DATA_W'(cnt_q) : '0;
        state_d = busy ? (done ? IDLE : CLEAR) : (start ? CLEAR : IDLE);
        cnt_d   = busy ? (done ? '0 : cnt_q + 1'b1) : (start ? ADDR_W'(1) : '0);
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/regfile_write_ctrl.sv
// regfile_write_ctrl: arbitrates the regfile write port between writeback, host loader and clear sequencer
module regfile_write_ctrl import regfile_write_ctrl_pkg::*; #(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MAX_WAIT   = 8,
    parameter int CLEAR_MODE = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              host_valid,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ready,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              stall_pipe,
    output logic              protocol_err,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_write_address,
    output logic [DATA_W-1:0] rf_data_in
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    logic              clr_busy, clr_done, start, denied, force_stall;
    logic [ADDR_W-1:0] clr_addr, wr_addr;
    logic [DATA_W-1:0] clr_data, wr_data;
    src_e              src;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              rf_write_en_q, rf_write_en_d;
    logic [ADDR_W-1:0] rf_write_address_q, rf_write_address_d;
    logic [DATA_W-1:0] rf_data_in_q, rf_data_in_d;
    logic              stall_pipe_q, stall_pipe_d;
    logic              protocol_err_q, protocol_err_d;
    regfile_clear_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLEAR_MODE(CLEAR_MODE)) u_clear (
        .clock(clock),
        .reset(reset),
        .start(start),
        .busy (clr_busy),
        .done (clr_done),
        .addr (clr_addr),
        .data (clr_data)
    );
    always_comb begin
        host_ready         = !clr_busy && !wb_valid;
        start              = clear_req && !clr_busy;
        denied             = !clr_busy && host_valid && wb_valid;
        force_stall        = denied && wait_cnt_q == WAIT_W'(MAX_WAIT - 1);
        wait_cnt_d         = (!denied || force_stall || start) ? '0 : wait_cnt_q + 1'b1;
        // a wb request during any stall cycle is a contract violation and is dropped
        src                = clr_busy ? SRC_CLR :
                             (wb_valid && !stall_pipe_q) ? SRC_WB :
                             (host_valid && host_ready) ? SRC_HOST : SRC_NONE;
        wr_addr            = src == SRC_CLR ? clr_addr : src == SRC_WB ? wb_addr : host_addr;
        wr_data            = src == SRC_CLR ? clr_data : src == SRC_WB ? wb_data : host_data;
        rf_write_en_d      = src != SRC_NONE && wr_addr != '0;
        rf_write_address_d = rf_write_en_d ? wr_addr : rf_write_address_q;
        rf_data_in_d       = rf_write_en_d ? wr_data : rf_data_in_q;
        stall_pipe_d       = start || (clr_busy && !clr_done) || force_stall;
        protocol_err_d     = protocol_err_q || (wb_valid && stall_pipe_q);
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt_q         <= '0;
            rf_write_en_q      <= 1'b0;
            rf_write_address_q <= '0;
            rf_data_in_q       <= '0;
            stall_pipe_q       <= 1'b0;
            protocol_err_q     <= 1'b0;
        end else begin
            wait_cnt_q         <= wait_cnt_d;
            rf_write_en_q      <= rf_write_en_d;
            rf_write_address_q <= rf_write_address_d;
            rf_data_in_q       <= rf_data_in_d;
            stall_pipe_q       <= stall_pipe_d;
            protocol_err_q     <= protocol_err_d;
        end
    end
    assign clear_busy       = clr_busy;
    assign stall_pipe       = stall_pipe_q;
    assign protocol_err     = protocol_err_q;
    assign rf_write_en      = rf_write_en_q;
    assign rf_write_address = rf_write_address_q;
    assign rf_data_in       = rf_data_in_q;
endmodule

// File: tb/tb_regfile_write_ctrl.sv
// tb_regfile_write_ctrl: directed scenario tasks for the regfile write controller
module tb_regfile_write_ctrl;
    logic        clock = 1'b0, reset = 1'b1;
    logic        wb_valid = 1'b0, host_valid = 1'b0, clear_req = 1'b0;
    logic [4:0]  wb_addr = '0, host_addr = '0;
    logic [31:0] wb_data = '0, host_data = '0;
    logic        host_ready, clear_busy, stall_pipe, protocol_err, rf_write_en;
    logic [4:0]  rf_write_address;
    logic [31:0] rf_data_in;
    logic [37:0] rf_obs, exp_rf;
    logic [2:0]  flg, exp_flg;
    int checks = 0, errors = 0;

    regfile_write_ctrl #(.ADDR_W(5), .DATA_W(32), .MAX_WAIT(8), .CLEAR_MODE(1)) dut (
        .clock(clock), .reset(reset),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .host_valid(host_valid), .host_addr(host_addr), .host_data(host_data),
        .host_ready(host_ready), .clear_req(clear_req), .clear_busy(clear_busy),
        .stall_pipe(stall_pipe), .protocol_err(protocol_err), .rf_write_en(rf_write_en),
        .rf_write_address(rf_write_address), .rf_data_in(rf_data_in)
    );

    always #5 clock = ~clock;
    assign rf_obs = {rf_write_en, rf_write_address, rf_data_in};
    assign flg    = {clear_busy, stall_pipe, protocol_err};

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic test_reset();
        cyc(); cyc(); #1;
        checks++; if (rf_obs !== 38'd0) begin errors++; $display("FAIL reset_rf: got %h want 0", rf_obs); end
        checks++; if (flg !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", flg); end
        reset = 1'b0;
        cyc(); #1;
        checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL reset_host_ready: got %b want 1", host_ready); end
    endtask

    task automatic test_wb_only();
        cyc(); wb_valid = 1; wb_addr = 3; wb_data = 32'hDEADBEEF;
        cyc(); wb_valid = 0; #1;
        exp_rf = {1'b1, 5'd3, 32'hDEADBEEF};
        checks++; if (rf_obs !== exp_rf) begin errors++; $display("FAIL wb_write: got %h want %h", rf_obs, exp_rf); end
        cyc(); #1;
        exp_rf = {1'b0, 5'd3, 32'hDEADBEEF};
        checks++; if (rf_obs !== exp_rf) begin errors++; $display("FAIL wb_en_drop: got %h want %h", rf_obs, exp_rf); end
    endtask

    task automatic test_contention();
        cyc(); wb_valid = 1; wb_addr = 4; wb_data = 32'h11; host_valid = 1; host_addr = 5; host_data = 32'h22; #1;
        checks++; if (host_ready !== 1'b0) begin errors++; $display("FAIL cont_ready_n: got %b want 0", host_ready); end
        cyc(); wb_valid = 0; #1;
        checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL cont_ready_n1: got %b want 1", host_ready); end
        exp_rf = {1'b1, 5'd4, 32'h11};
        checks++; if (rf_obs !== exp_rf) begin errors++; $display("FAIL cont_wb_write: got %h want %h", rf_obs, exp_rf); end
        cyc(); host_valid = 0; #1;
        exp_rf = {1'b1, 5'd5, 32'h22};
        checks++; if (rf_obs !== exp_rf) begin errors++; $display("FAIL cont_host_write: got %h want %h", rf_obs, exp_rf); end
        cyc(); #1;
        checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL cont_idle: got %b want 0", rf_write_en); end
    endtask

    task automatic test_starvation();
        for (int i = 0; i < 8; i++) begin
            cyc(); wb_valid = 1; wb_addr = 2; wb_data = 32'(i); host_valid = 1; host_addr = 7; host_data = 32'h77; #1;
            checks++; if (stall_pipe !== 1'b0) begin errors++; $display("FAIL starve_stall_early c%0d: got %b want 0", i, stall_pipe); end
            checks++; if (host_ready !== 1'b0) begin errors++; $display("FAIL starve_ready c%0d: got %b want 0", i, host_ready); end
        end
        cyc(); wb_valid = 0; #1;
        checks++; if (stall_pipe !== 1'b1) begin errors++; $display("FAIL starve_stall: got %b want 1", stall_pipe); end
        checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL starve_grant: got %b want 1", host_ready); end
        exp_rf = {1'b1, 5'd2, 32'd7};
        checks++; if (rf_obs !== exp_rf) begin errors++; $display("FAIL starve_last_wb: got %h want %h", rf_obs, exp_rf); end
        cyc(); host_valid = 0; #1;
        checks++; if (stall_pipe !== 1'b0) begin errors++; $display("FAIL starve_stall_once: got %b want 0", stall_pipe); end
        exp_rf = {1'b1, 5'd7, 32'h77};
        checks++; if (rf_obs !== exp_rf) begin errors++; $display("FAIL starve_host_write: got %h want %h", rf_obs, exp_rf); end
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL starve_perr: got %b want 0", protocol_err); end
    endtask

    task automatic test_clear();
        cyc(); clear_req = 1;
        for (int k = 1; k <= 31; k++) begin
            cyc(); clear_req = (k == 5); host_valid = 1; host_addr = 9; host_data = 32'h99; #1;
            checks++; if (flg !== 3'b110) begin errors++; $display("FAIL clear_flags k%0d: got %b want 110", k, flg); end
            checks++; if (host_ready !== 1'b0) begin errors++; $display("FAIL clear_ready k%0d: got %b want 0", k, host_ready); end
            if (k >= 2) begin
                exp_rf = {1'b1, 5'(k - 1), 32'(k - 1)};
                checks++; if (rf_obs !== exp_rf) begin errors++; $display("FAIL clear_write k%0d: got %h want %h", k, rf_obs, exp_rf); end
            end
        end
        cyc(); #1;
        checks++; if (flg !== 3'b000) begin errors++; $display("FAIL clear_end_flags: got %b want 000", flg); end
        exp_rf = {1'b1, 5'd31, 32'd31};
        checks++; if (rf_obs !== exp_rf) begin errors++; $display("FAIL clear_last_write: got %h want %h", rf_obs, exp_rf); end
        checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL clear_end_ready: got %b want 1", host_ready); end
        cyc(); host_valid = 0; #1;
        exp_rf = {1'b1, 5'd9, 32'h99};
        checks++; if (rf_obs !== exp_rf) begin errors++; $display("FAIL clear_host_after: got %h want %h", rf_obs, exp_rf); end
        cyc(); #1;
        checks++; if (flg !== 3'b000) begin errors++; $display("FAIL clear_no_restart: got %b want 000", flg); end
    endtask

    task automatic test_addr_zero();
        cyc(); host_valid = 1; host_addr = 0; host_data = 32'hFFFFFFFF; #1;
        checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL zero_host_ready: got %b want 1", host_ready); end
        cyc(); host_valid = 0; wb_valid = 1; wb_addr = 0; wb_data = 32'h5; #1;
        exp_rf = {1'b0, 5'd9, 32'h99};
        checks++; if (rf_obs !== exp_rf) begin errors++; $display("FAIL zero_host_write: got %h want %h", rf_obs, exp_rf); end
        cyc(); wb_valid = 0; #1;
        checks++; if (rf_obs !== exp_rf) begin errors++; $display("FAIL zero_wb_write: got %h want %h", rf_obs, exp_rf); end
    endtask

    task automatic test_reset_mid_clear();
        int writes = 0;
        cyc(); clear_req = 1;
        for (int k = 1; k <= 10; k++) begin
            cyc(); clear_req = 0;
        end
        #1;
        exp_rf = {1'b1, 5'd9, 32'd9};
        checks++; if (rf_obs !== exp_rf) begin errors++; $display("FAIL rst_pre_write: got %h want %h", rf_obs, exp_rf); end
        reset = 1; #1;
        checks++; if (rf_obs !== 38'd0) begin errors++; $display("FAIL rst_async_rf: got %h want 0", rf_obs); end
        checks++; if (flg !== 3'b000) begin errors++; $display("FAIL rst_async_flags: got %b want 000", flg); end
        cyc(); reset = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(); #1;
            if (rf_write_en || clear_busy) writes++;
        end
        checks++; if (writes !== 0) begin errors++; $display("FAIL rst_no_resume: got %0d writes want 0", writes); end
    endtask

    task automatic test_protocol_err();
        cyc(); clear_req = 1;
        for (int k = 1; k <= 3; k++) begin
            cyc(); clear_req = 0;
        end
        wb_valid = 1; wb_addr = 20; wb_data = 32'hABCD;
        cyc(); wb_valid = 0; #1;
        checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL perr_set: got %b want 1", protocol_err); end
        exp_rf = {1'b1, 5'd3, 32'd3};
        checks++; if (rf_obs !== exp_rf) begin errors++; $display("FAIL perr_wb_dropped: got %h want %h", rf_obs, exp_rf); end
        for (int k = 5; k <= 32; k++) cyc();
        #1;
        exp_flg = 3'b001;
        checks++; if (flg !== exp_flg) begin errors++; $display("FAIL perr_sticky: got %b want %b", flg, exp_flg); end
        exp_rf = {1'b1, 5'd31, 32'd31};
        checks++; if (rf_obs !== exp_rf) begin errors++; $display("FAIL perr_clear_done: got %h want %h", rf_obs, exp_rf); end
        reset = 1; #1;
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL perr_reset: got %b want 0", protocol_err); end
        cyc(); reset = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_wb_only();
        test_contention();
        test_starvation();
        test_clear();
        test_addr_zero();
        test_reset_mid_clear();
        test_protocol_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
